arcade_input_ctrl: RTL and testbench

// - Parametrised player-input front end for arcade cores; sits between hps_io (ps2_key, joysticks) and the game core.
// - Merges the fixed PS/2 key map with per-player joysticks and applies 0/90/180/270 control rotation.
// - Adds per-player autofire on button 0 and a stretched, edge-triggered coin pulse.
// - All outputs are registered, with optional active-low polarity.

---
 rtl/arcade_input_ctrl_if.sv | 27 ++
 rtl/arcade_input_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_arcade_input_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arcade_input_ctrl_if.sv
// Player-input bundle between the hps_io side (master) and the input
// controller (slave): PS/2 events, joysticks, rotation and autofire enables
// in; merged, rotated and stretched player controls out.
interface arcade_input_ctrl_if #(
  parameter int NPLAYERS = 2,
  parameter int NBUTTONS = 2
);
  logic [10:0]                  ps2_key;
  logic [16*NPLAYERS-1:0]       joy_in;
  logic [1:0]                   rotate;
  logic [NPLAYERS-1:0]          autofire_en;
  logic [4*NPLAYERS-1:0]        p_dir;
  logic [NBUTTONS*NPLAYERS-1:0] p_btn;
  logic [NPLAYERS-1:0]          start;
  logic [1:0]                   coin;
  logic                         test;

  modport master (
    output ps2_key, joy_in, rotate, autofire_en,
    input  p_dir, p_btn, start, coin, test
  );

  modport slave (
    input  ps2_key, joy_in, rotate, autofire_en,
    output p_dir, p_btn, start, coin, test
  );
endinterface

// File: rtl/arcade_input_ctrl.sv
// Arcade player-input front end: latches the fixed PS/2 key map, ORs it with
// the per-player joysticks, rotates directions, adds autofire on button 0 and
// stretches edge-triggered coin requests. Every output comes from a flop.
module arcade_input_ctrl #(
  parameter int NPLAYERS   = 2,
  parameter int NBUTTONS   = 2,
  parameter int COIN_PULSE = 200000,
  parameter int AF_HALF    = 400000,
  parameter int START_COIN = 1,
  parameter int ACTIVE_LOW = 0
) (
  input  logic               clk_sys,
  input  logic               RESET,
  arcade_input_ctrl_if.slave io
);

  localparam int CW = $clog2(COIN_PULSE + 1);
  localparam int AW = $clog2(AF_HALF + 1);
  // start and coin bit positions inside a 16-bit joystick word
  localparam int SB = 4 + NBUTTONS;
  localparam int CB = 5 + NBUTTONS;
  localparam logic INV = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_PULSE);
  localparam logic [AW-1:0] AF_LOAD   = AW'(AF_HALF - 1);

  // keyboard state; the fixed map only covers P1 and P2
  logic            tog_q, tog_d;
  logic            primed_q, primed_d;
  logic [1:0][3:0] kdir_q, kdir_d;     // {U,D,L,R}
  logic [1:0][1:0] kbtn_q, kbtn_d;
  logic [1:0]      kstart_q, kstart_d;
  logic [1:0]      kcoin_q, kcoin_d;
  logic            ktest_q, ktest_d;
  logic [8:0]      code;
  logic            pressed;

  // merged raw inputs
  logic [NPLAYERS-1:0][3:0]          raw_dir;
  logic [NPLAYERS-1:0][NBUTTONS-1:0] raw_btn;
  logic [NPLAYERS-1:0]               raw_start;
  logic [NPLAYERS-1:0]               raw_coin;
  logic [1:0]                        coin_req;

  // autofire and coin timers
  logic [NPLAYERS-1:0][AW-1:0] af_cnt_q, af_cnt_d;
  logic [NPLAYERS-1:0]         af_run_q, af_run_d;
  logic [NPLAYERS-1:0]         af_ph_q, af_ph_d;
  logic [1:0][CW-1:0]          coin_cnt_q, coin_cnt_d;
  logic [1:0]                  req_q, req_d;

  // output registers
  logic [4*NPLAYERS-1:0]        p_dir_q, p_dir_d;
  logic [NBUTTONS*NPLAYERS-1:0] p_btn_q, p_btn_d;
  logic [NPLAYERS-1:0]          start_q, start_d;
  logic [1:0]                   coin_q, coin_d;
  logic                         test_q, test_d;

  function automatic logic [3:0] rotate_udlr(input logic [3:0] udlr,
                                             input logic [1:0] rot);
    logic u, d, l, r;
    {u, d, l, r} = udlr;
    case (rot)
      2'b00:   return {u, d, l, r};
      2'b01:   return {l, r, d, u};
      2'b10:   return {d, u, r, l};
      default: return {r, l, u, d};
    endcase
  endfunction

  // PS/2 event detect and key-map decode; the first edge after reset only primes
  always_comb begin
    tog_d    = tog_q;
    primed_d = 1'b1;
    kdir_d   = kdir_q;
    kbtn_d   = kbtn_q;
    kstart_d = kstart_q;
    kcoin_d  = kcoin_q;
    ktest_d  = ktest_q;
    code     = io.ps2_key[8:0];
    pressed  = io.ps2_key[9];
    if (!primed_q) begin
      tog_d = io.ps2_key[10];
    end else if (io.ps2_key[10] != tog_q) begin
      tog_d = io.ps2_key[10];
      // P1 arrows are accepted with or without the E0 prefix
      if      (code[7:0] == 8'h75) kdir_d[0][3] = pressed;
      else if (code[7:0] == 8'h72) kdir_d[0][2] = pressed;
      else if (code[7:0] == 8'h6B) kdir_d[0][1] = pressed;
      else if (code[7:0] == 8'h74) kdir_d[0][0] = pressed;
      else begin
        case (code)
          9'h029, 9'h014: kbtn_d[0][0] = pressed;
          9'h011:         kbtn_d[0][1] = pressed;
          9'h02D:         kdir_d[1][3] = pressed;
          9'h02B:         kdir_d[1][2] = pressed;
          9'h023:         kdir_d[1][1] = pressed;
          9'h034:         kdir_d[1][0] = pressed;
          9'h01C:         kbtn_d[1][0] = pressed;
          9'h01B:         kbtn_d[1][1] = pressed;
          9'h005, 9'h016: kstart_d[0]  = pressed;
          9'h006, 9'h01E: kstart_d[1]  = pressed;
          9'h02E:         kcoin_d[0]   = pressed;
          9'h036:         kcoin_d[1]   = pressed;
          9'h02C:         ktest_d      = pressed;
          default: ;
        endcase
      end
    end
  end

  // merge key latches with joystick words into raw per-player controls
  always_comb begin
    raw_dir   = '0;
    raw_btn   = '0;
    raw_start = '0;
    raw_coin  = '0;
    for (int p = 0; p < NPLAYERS; p++) begin
      raw_dir[p]   = io.joy_in[16*p +: 4];
      raw_btn[p]   = io.joy_in[16*p+4 +: NBUTTONS];
      raw_start[p] = io.joy_in[16*p+SB];
      raw_coin[p]  = io.joy_in[16*p+CB];
      if (p < 2) begin
        raw_dir[p]   = raw_dir[p] | kdir_q[p[0]];
        raw_start[p] = raw_start[p] | kstart_q[p[0]];
        for (int b = 0; b < NBUTTONS && b < 2; b++)
          raw_btn[p][b] = raw_btn[p][b] | kbtn_q[p[0]][b[0]];
      end
    end
  end

  // coin requests: P2 feeds slot 1, every other player and optionally any start feed slot 0
  always_comb begin
    coin_req = kcoin_q;
    for (int p = 0; p < NPLAYERS; p++) begin
      if (p == 1) coin_req[1] = coin_req[1] | raw_coin[p];
      else        coin_req[0] = coin_req[0] | raw_coin[p];
    end
    if (START_COIN != 0) coin_req[0] = coin_req[0] | (|raw_start);
  end

  // next output values: rotation, autofire phase timers, coin pulse timers
  always_comb begin
    logic [NBUTTONS-1:0] btn;
    btn      = '0;
    p_dir_d  = '0;
    p_btn_d  = '0;
    af_cnt_d = af_cnt_q;
    af_run_d = af_run_q;
    af_ph_d  = af_ph_q;
    start_d  = raw_start ^ {NPLAYERS{INV}};
    test_d   = ktest_q;
    for (int p = 0; p < NPLAYERS; p++) begin
      p_dir_d[4*p +: 4] = rotate_udlr(raw_dir[p], io.rotate) ^ {4{INV}};
      btn = raw_btn[p];
      if (io.autofire_en[p] && raw_btn[p][0]) begin
        if (!af_run_q[p]) begin
          // first held cycle opens a high phase
          af_run_d[p] = 1'b1;
          af_ph_d[p]  = 1'b1;
          af_cnt_d[p] = AF_LOAD;
          btn[0]      = 1'b1;
        end else if (af_cnt_q[p] == '0) begin
          af_ph_d[p]  = ~af_ph_q[p];
          af_cnt_d[p] = AF_LOAD;
          btn[0]      = ~af_ph_q[p];
        end else begin
          af_cnt_d[p] = af_cnt_q[p] - AW'(1);
          btn[0]      = af_ph_q[p];
        end
      end else begin
        af_run_d[p] = 1'b0;
        af_ph_d[p]  = 1'b0;
        af_cnt_d[p] = '0;
      end
      p_btn_d[NBUTTONS*p +: NBUTTONS] = btn ^ {NBUTTONS{INV}};
    end
    // a slot is idle only at terminal count; edges seen while busy are dropped
    for (int k = 0; k < 2; k++) begin
      coin_d[k] = (coin_cnt_q[k] != '0);
      if (coin_cnt_q[k] != '0)
        coin_cnt_d[k] = coin_cnt_q[k] - CW'(1);
      else if (coin_req[k] && !req_q[k])
        coin_cnt_d[k] = COIN_LOAD;
      else
        coin_cnt_d[k] = '0;
    end
    req_d = coin_req;
  end

  // state and output registers; reset drops held keys and aborts pulses
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      tog_q      <= 1'b0;
      primed_q   <= 1'b0;
      kdir_q     <= '0;
      kbtn_q     <= '0;
      kstart_q   <= '0;
      kcoin_q    <= '0;
      ktest_q    <= 1'b0;
      af_cnt_q   <= '0;
      af_run_q   <= '0;
      af_ph_q    <= '0;
      coin_cnt_q <= '0;
      req_q      <= '0;
      p_dir_q    <= {4*NPLAYERS{INV}};
      p_btn_q    <= {NBUTTONS*NPLAYERS{INV}};
      start_q    <= {NPLAYERS{INV}};
      coin_q     <= '0;
      test_q     <= 1'b0;
    end else begin
      tog_q      <= tog_d;
      primed_q   <= primed_d;
      kdir_q     <= kdir_d;
      kbtn_q     <= kbtn_d;
      kstart_q   <= kstart_d;
      kcoin_q    <= kcoin_d;
      ktest_q    <= ktest_d;
      af_cnt_q   <= af_cnt_d;
      af_run_q   <= af_run_d;
      af_ph_q    <= af_ph_d;
      coin_cnt_q <= coin_cnt_d;
      req_q      <= req_d;
      p_dir_q    <= p_dir_d;
      p_btn_q    <= p_btn_d;
      start_q    <= start_d;
      coin_q     <= coin_d;
      test_q     <= test_d;
    end
  end

  assign io.p_dir = p_dir_q;
  assign io.p_btn = p_btn_q;
  assign io.start = start_q;
  assign io.coin  = coin_q;
  assign io.test  = test_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Bench for arcade_input_ctrl: two instances (active-high and active-low
// outputs) share one stimulus stream and are compared every cycle against a
// behavioural reference built from the key map, rotation table, autofire
// period and coin pulse rules.
module tb_arcade_input_ctrl;
  localparam int NP = 2;
  localparam int NB = 2;
  localparam int CP = 5;
  localparam int AH = 3;
  localparam int SB = 4 + NB;
  localparam int CB = 5 + NB;
  localparam logic [4*NP-1:0]  ALL_DIR   = {4*NP{1'b1}};
  localparam logic [NB*NP-1:0] ALL_BTN   = {NB*NP{1'b1}};
  localparam logic [NP-1:0]    ALL_START = {NP{1'b1}};
  localparam int NCODES = 27;

  logic clk_sys = 1'b0;
  logic RESET   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  logic [10:0]      ps2_key = '0;
  logic [16*NP-1:0] joy_in  = '0;
  logic [1:0]       rotate  = '0;
  logic [NP-1:0]    af_en   = '0;

  arcade_input_ctrl_if #(.NPLAYERS(NP), .NBUTTONS(NB)) bus ();
  arcade_input_ctrl_if #(.NPLAYERS(NP), .NBUTTONS(NB)) bus_al ();

  assign bus.ps2_key        = ps2_key;
  assign bus.joy_in         = joy_in;
  assign bus.rotate         = rotate;
  assign bus.autofire_en    = af_en;
  assign bus_al.ps2_key     = ps2_key;
  assign bus_al.joy_in      = joy_in;
  assign bus_al.rotate      = rotate;
  assign bus_al.autofire_en = af_en;

  arcade_input_ctrl #(.NPLAYERS(NP), .NBUTTONS(NB), .COIN_PULSE(CP), .AF_HALF(AH),
                      .START_COIN(1), .ACTIVE_LOW(0))
    dut (.clk_sys(clk_sys), .RESET(RESET), .io(bus.slave));

  arcade_input_ctrl #(.NPLAYERS(NP), .NBUTTONS(NB), .COIN_PULSE(CP), .AF_HALF(AH),
                      .START_COIN(1), .ACTIVE_LOW(1))
    dut_al (.clk_sys(clk_sys), .RESET(RESET), .io(bus_al.slave));

  logic [8:0] codes [0:NCODES-1] = '{
    9'h075, 9'h175, 9'h072, 9'h06B, 9'h16B, 9'h074, 9'h029, 9'h014, 9'h114,
    9'h011, 9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01C, 9'h01B, 9'h005, 9'h016,
    9'h006, 9'h01E, 9'h02E, 9'h036, 9'h02C, 9'h129, 9'h0AA, 9'h1F0, 9'h000};

  // reference model state: role 0..5 P1 U,D,L,R,b0,b1; 6..11 P2 same;
  // 12,13 start P1/P2; 14,15 coin0/1; 16 test
  bit  prim, tog;
  bit  role [17];
  int  af_hold [NP];
  int  pulse_s [2];
  int  pulse_e [2];
  bit  prev_req [2];
  int  cyc = 0;
  logic [4*NP-1:0]  e_dir;
  logic [NB*NP-1:0] e_btn;
  logic [NP-1:0]    e_start;
  logic [1:0]       e_coin;
  logic             e_test;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got 'h%0h, want 'h%0h", tag, cyc, obs, exp);
  endtask

  function automatic int role_of(input logic [8:0] code);
    logic [7:0] lo;
    lo = code[7:0];
    if (lo == 8'h75) return 0;
    if (lo == 8'h72) return 1;
    if (lo == 8'h6B) return 2;
    if (lo == 8'h74) return 3;
    case (code)
      9'h029, 9'h014: return 4;
      9'h011:         return 5;
      9'h02D:         return 6;
      9'h02B:         return 7;
      9'h023:         return 8;
      9'h034:         return 9;
      9'h01C:         return 10;
      9'h01B:         return 11;
      9'h005, 9'h016: return 12;
      9'h006, 9'h01E: return 13;
      9'h02E:         return 14;
      9'h036:         return 15;
      9'h02C:         return 16;
      default:        return -1;
    endcase
  endfunction

  function automatic logic [3:0] rot_ref(input bit u, input bit d, input bit l,
                                         input bit r, input logic [1:0] rt);
    case (rt)
      2'd0:    return {u, d, l, r};
      2'd1:    return {l, r, d, u};
      2'd2:    return {d, u, r, l};
      default: return {r, l, u, d};
    endcase
  endfunction

  task automatic model_reset();
    prim = 0;
    tog  = 0;
    for (int i = 0; i < 17; i++) role[i] = 0;
    for (int p = 0; p < NP; p++) af_hold[p] = 0;
    for (int k = 0; k < 2; k++) begin
      pulse_s[k]  = 0;
      pulse_e[k]  = -1;
      prev_req[k] = 0;
    end
    e_dir = '0; e_btn = '0; e_start = '0; e_coin = '0; e_test = 1'b0;
  endtask

  // outputs for this edge come from state and inputs present before the edge
  task automatic model_step();
    bit u, d, l, r, raw_b, any_start;
    bit [1:0] req;
    int ri;
    any_start = 0;
    req = '0;
    for (int p = 0; p < NP; p++) begin
      u = role[6*p+0] | joy_in[16*p+3];
      d = role[6*p+1] | joy_in[16*p+2];
      l = role[6*p+2] | joy_in[16*p+1];
      r = role[6*p+3] | joy_in[16*p+0];
      e_dir[4*p +: 4] = rot_ref(u, d, l, r, rotate);
      for (int b = 0; b < NB; b++) begin
        raw_b = joy_in[16*p+4+b] | role[6*p+4+b];
        if (b == 0 && af_en[p] && raw_b) begin
          e_btn[NB*p] = ((af_hold[p] / AH) % 2) == 0;
          af_hold[p]++;
        end else begin
          if (b == 0) af_hold[p] = 0;
          e_btn[NB*p+b] = raw_b;
        end
      end
      e_start[p] = joy_in[16*p+SB] | role[12+p];
      any_start  = any_start | e_start[p];
      if (p == 1) req[1] = req[1] | joy_in[16*p+CB];
      else        req[0] = req[0] | joy_in[16*p+CB];
    end
    req[0] = req[0] | role[14] | any_start;
    req[1] = req[1] | role[15];
    e_test = role[16];
    for (int k = 0; k < 2; k++) begin
      e_coin[k] = (cyc >= pulse_s[k]) && (cyc <= pulse_e[k]);
      if (req[k] && !prev_req[k] && cyc > pulse_e[k]) begin
        pulse_s[k] = cyc + 1;
        pulse_e[k] = cyc + CP;
      end
      prev_req[k] = req[k];
    end
    if (!prim) begin
      prim = 1;
      tog  = ps2_key[10];
    end else if (ps2_key[10] != tog) begin
      tog = ps2_key[10];
      ri  = role_of(ps2_key[8:0]);
      if (ri >= 0) role[ri] = ps2_key[9];
    end
  endtask

  task automatic compare_all();
    chk("p_dir",    bus.p_dir,    e_dir);
    chk("p_btn",    bus.p_btn,    e_btn);
    chk("start",    bus.start,    e_start);
    chk("coin",     bus.coin,     e_coin);
    chk("test",     bus.test,     e_test);
    chk("al_p_dir", bus_al.p_dir, e_dir ^ ALL_DIR);
    chk("al_p_btn", bus_al.p_btn, e_btn ^ ALL_BTN);
    chk("al_start", bus_al.start, e_start ^ ALL_START);
    chk("al_coin",  bus_al.coin,  e_coin);
    chk("al_test",  bus_al.test,  e_test);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    if (RESET) model_reset();
    else       model_step();
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic send_key(input bit pr, input logic [8:0] code);
    ps2_key = {~ps2_key[10], pr, code};
  endtask

  int  hi, rises;
  bit  last;
  int  idx;

  initial begin
    model_reset();
    tick();
    tick();
    chk("rst_dir",    bus.p_dir,    0);
    chk("rst_al_dir", bus_al.p_dir, 8'hFF);
    chk("rst_al_btn", bus_al.p_btn, 4'hF);
    chk("rst_al_st",  bus_al.start, 2'h3);
    chk("rst_al_coin", bus_al.coin, 0);

    // release reset with the toggle already high: no spurious event
    ps2_key = {1'b1, 1'b1, 9'h02C};
    RESET = 1'b0;
    repeat (4) tick();
    chk("primed_test", bus.test, 0);
    send_key(1, 9'h02C);
    tick(); tick();
    chk("test_on", bus.test, 1);
    send_key(0, 9'h02C);
    tick(); tick();
    chk("test_off", bus.test, 0);

    // P1 up from the keyboard, two-cycle latency
    send_key(1, 9'h075);
    tick();
    chk("key_up_lat", bus.p_dir[3:0], 4'b0000);
    tick();
    chk("key_up", bus.p_dir[3:0], 4'b1000);
    send_key(0, 9'h075);
    tick(); tick();
    chk("key_up_rel", bus.p_dir[3:0], 4'b0000);

    // joystick up through each rotation, one-cycle latency
    joy_in[3] = 1'b1;
    rotate = 2'b01; tick();
    chk("rot90", bus.p_dir[3:0], 4'b0001);
    rotate = 2'b10; tick();
    chk("rot180", bus.p_dir[3:0], 4'b0100);
    rotate = 2'b11; tick();
    chk("rot270", bus.p_dir[3:0], 4'b0010);
    joy_in = '0; rotate = 2'b00;
    tick();

    // coin key held: one pulse of exactly CP cycles, re-armed by release
    send_key(1, 9'h02E);
    hi = 0; rises = 0; last = 0;
    repeat (20) begin
      tick();
      if (bus.coin[0]) hi++;
      if (bus.coin[0] && !last) rises++;
      last = bus.coin[0];
    end
    chk("coin_len", hi, CP);
    chk("coin_single", rises, 1);
    send_key(0, 9'h02E);
    repeat (3) tick();
    send_key(1, 9'h02E);
    hi = 0;
    repeat (12) begin
      tick();
      if (bus.coin[0]) hi++;
    end
    chk("coin_len2", hi, CP);
    send_key(0, 9'h02E);
    repeat (3) tick();

    // autofire on P1 button 0 via key 029
    af_en[0] = 1'b1;
    send_key(1, 9'h029);
    tick();
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("af_pat", bus.p_btn[0], ((i / AH) % 2) == 0);
    end
    send_key(0, 9'h029);
    tick(); tick();
    chk("af_rel", bus.p_btn[0], 0);
    af_en = '0;
    tick();

    // reset in the middle of a coin pulse aborts it at once
    joy_in[CB] = 1'b1;
    tick(); tick(); tick();
    chk("coin_joy", bus.coin[0], 1);
    RESET = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("rst_abort", bus.coin, 0);
    joy_in = '0;
    tick(); tick();
    RESET = 1'b0;
    tick();

    // randomized traffic against the reference
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0)
        send_key(1'($urandom_range(1)), codes[$urandom_range(NCODES - 1)]);
      else if ($urandom_range(7) == 0)
        ps2_key[9:0] = 10'($urandom);
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(5) == 0) begin
          idx = 16 * p + $urandom_range(15);
          joy_in[idx] = ~joy_in[idx];
        end
      end
      if ($urandom_range(15) == 0) rotate = 2'($urandom_range(3));
      if ($urandom_range(31) == 0) af_en = NP'($urandom);
      if (i == 700) begin
        RESET = 1'b1;
        #1;
        model_reset();
        compare_all();
        tick();
        RESET = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
